// File: rtl/cv32e40p_ft_supervisor.sv
// Fault-tolerance supervisor for the triplicated CV32E40P: counts voter events,
// tracks replica health, raises a sticky alert and exposes a small register window.
module cv32e40p_ft_supervisor #(
  parameter int CNT_W           = 16,
  parameter int ALERT_THRESHOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        err_detected_i,
  input  logic        err_corrected_i,
  input  logic [2:0]  is_broken_i,
  output logic [2:0]  set_broken_o,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        alert_o
);

  typedef enum logic [1:0] {
    HEALTHY  = 2'd0,
    DEGRADED = 2'd1,
    FAILED   = 2'd2
  } health_e;

  localparam logic [1:0]       ADDR_STATUS = 2'd0;
  localparam logic [1:0]       ADDR_COUNT  = 2'd1;
  localparam logic [1:0]       ADDR_FORCE  = 2'd2;
  localparam logic [1:0]       ADDR_THRESH = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  health_e           state_q, state_d;
  logic [CNT_W-1:0]  det_cnt_q, det_cnt_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [2:0]        force_q, force_d;
  logic [15:0]       thresh_q, thresh_d;
  logic              alert_q, alert_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        wr_en;
  logic        rd_en;
  logic [1:0]  broken_cnt;
  logic [15:0] det_ext;
  logic [15:0] corr_ext;
  logic        alert_set;
  logic        alert_clr;
  logic        unused_wdata;

  assign gnt_o        = req_i;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign alert_o      = alert_q;
  assign set_broken_o = force_q;

  assign wr_en        = req_i & we_i;
  assign rd_en        = req_i & ~we_i;
  assign broken_cnt   = {1'b0, is_broken_i[0]} + {1'b0, is_broken_i[1]} + {1'b0, is_broken_i[2]};
  assign det_ext      = 16'(det_cnt_q);
  assign corr_ext     = 16'(corr_cnt_q);
  assign unused_wdata = ^{wdata_i[31:16], wdata_i[4:3]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      HEALTHY: begin
        if (broken_cnt >= 2'd2)      state_d = FAILED;
        else if (broken_cnt == 2'd1) state_d = DEGRADED;
      end
      DEGRADED: begin
        if (broken_cnt >= 2'd2)      state_d = FAILED;
        else if (broken_cnt == 2'd0) state_d = HEALTHY;
      end
      FAILED:  state_d = FAILED;
      default: state_d = FAILED;
    endcase
  end

  // A counter clear wins over an error event arriving in the same cycle.
  always_comb begin
    det_cnt_d  = det_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (wr_en && addr_i == ADDR_COUNT) begin
      det_cnt_d  = '0;
      corr_cnt_d = '0;
    end else if (err_detected_i) begin
      if (det_cnt_q != CNT_MAX) det_cnt_d = det_cnt_q + 1'b1;
      if (err_corrected_i && corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    force_d  = force_q;
    thresh_d = thresh_q;
    if (wr_en && addr_i == ADDR_FORCE)  force_d  = wdata_i[2:0];
    if (wr_en && addr_i == ADDR_THRESH) thresh_d = wdata_i[15:0];
  end

  // Any set source overrides a software clear in the same cycle.
  always_comb begin
    alert_set = (err_detected_i & ~err_corrected_i)
              | (state_d == FAILED && state_q != FAILED)
              | (thresh_q != 16'd0 && det_ext == thresh_q);
    alert_clr = wr_en && addr_i == ADDR_STATUS && wdata_i[5];
    alert_d   = alert_set | (alert_q & ~alert_clr);
  end

  always_comb begin
    rvalid_d = req_i;
    rdata_d  = 32'd0;
    if (rd_en) begin
      case (addr_i)
        ADDR_STATUS: rdata_d = {26'd0, alert_q, is_broken_i, state_q};
        ADDR_COUNT:  rdata_d = {corr_ext, det_ext};
        ADDR_FORCE:  rdata_d = {29'd0, force_q};
        ADDR_THRESH: rdata_d = {16'd0, thresh_q};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HEALTHY;
      det_cnt_q  <= '0;
      corr_cnt_q <= '0;
      force_q    <= 3'd0;
      thresh_q   <= 16'(ALERT_THRESHOLD);
      alert_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      det_cnt_q  <= det_cnt_d;
      corr_cnt_q <= corr_cnt_d;
      force_q    <= force_d;
      thresh_q   <= thresh_d;
      alert_q    <= alert_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_ft_supervisor.sv
// Directed testbench for cv32e40p_ft_supervisor: a default instance plus a
// CNT_W=4 instance sharing the same stimulus to exercise counter saturation.
module tb_cv32e40p_ft_supervisor;

  logic        clk;
  logic        rst;
  logic        err_detected;
  logic        err_corrected;
  logic [2:0]  is_broken;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;

  logic [2:0]  set_broken;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        alert;

  logic [2:0]  set_broken4;
  logic        gnt4;
  logic        rvalid4;
  logic [31:0] rdata4;
  logic        alert4;

  int totalCount;
  int badCount;

  logic [31:0] readData;
  logic [31:0] readData4;

  cv32e40p_ft_supervisor dut (
    .clk             (clk),
    .rst             (rst),
    .err_detected_i  (err_detected),
    .err_corrected_i (err_corrected),
    .is_broken_i     (is_broken),
    .set_broken_o    (set_broken),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .gnt_o           (gnt),
    .rvalid_o        (rvalid),
    .rdata_o         (rdata),
    .alert_o         (alert)
  );

  cv32e40p_ft_supervisor #(.CNT_W(4)) dut4 (
    .clk             (clk),
    .rst             (rst),
    .err_detected_i  (err_detected),
    .err_corrected_i (err_corrected),
    .is_broken_i     (is_broken),
    .set_broken_o    (set_broken4),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .gnt_o           (gnt4),
    .rvalid_o        (rvalid4),
    .rdata_o         (rdata4),
    .alert_o         (alert4)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Holds the error/broken inputs for a number of cycles, then drops the error strobes.
  task automatic applyStimulus(input logic det, input logic corr, input logic [2:0] brk, input int cycles);
    err_detected  = det;
    err_corrected = corr;
    is_broken     = brk;
    repeat (cycles) @(posedge clk);
    #1;
    err_detected  = 1'b0;
    err_corrected = 1'b0;
  endtask

  // One-cycle read; response is sampled 1 ns after the accepting edge.
  task automatic doRead(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d4);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    checkOutput("gnt_follows_req", {31'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    checkOutput("read_rvalid", {31'd0, rvalid}, 32'd1);
    d  = rdata;
    d4 = rdata4;
  endtask

  // One-cycle write, optionally with error strobes in the same cycle.
  task automatic doWrite(input logic [1:0] a, input logic [31:0] v, input logic det, input logic corr);
    req           = 1'b1;
    we            = 1'b1;
    addr          = a;
    wdata         = v;
    err_detected  = det;
    err_corrected = corr;
    @(posedge clk);
    #1;
    req           = 1'b0;
    we            = 1'b0;
    wdata         = 32'd0;
    err_detected  = 1'b0;
    err_corrected = 1'b0;
    checkOutput("write_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("write_rdata_zero", rdata, 32'd0);
  endtask

  initial begin
    totalCount    = 0;
    badCount      = 0;
    rst           = 1'b1;
    err_detected  = 1'b0;
    err_corrected = 1'b0;
    is_broken     = 3'b000;
    req           = 1'b0;
    we            = 1'b0;
    addr          = 2'd0;
    wdata         = 32'd0;

    // Reset values, and grant still tracks request while in reset.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_alert", {31'd0, alert}, 32'd0);
    checkOutput("rst_set_broken", {29'd0, set_broken}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    req = 1'b1;
    #1;
    checkOutput("rst_gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_no_rvalid", {31'd0, rvalid}, 32'd0);
    req = 1'b0;
    #1;
    checkOutput("rst_gnt_low", {31'd0, gnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_no_rvalid", {31'd0, rvalid}, 32'd0);

    doRead(2'd0, readData, readData4);
    checkOutput("status_after_reset", readData, 32'h0000_0000);
    doRead(2'd3, readData, readData4);
    checkOutput("thresh_after_reset", readData, 32'h0000_0008);
    @(posedge clk);
    #1;
    checkOutput("rvalid_idle", {31'd0, rvalid}, 32'd0);
    checkOutput("rdata_idle", rdata, 32'd0);

    // Corrected errors accumulate, threshold of 8 raises the alert.
    applyStimulus(1'b1, 1'b1, 3'b000, 5);
    doRead(2'd1, readData, readData4);
    checkOutput("count_5_5", readData, 32'h0005_0005);
    checkOutput("alert_below_thresh", {31'd0, alert}, 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b000, 3);
    applyStimulus(1'b0, 1'b0, 3'b000, 1);
    checkOutput("alert_at_thresh", {31'd0, alert}, 32'd1);
    doRead(2'd1, readData, readData4);
    checkOutput("count_8_8", readData, 32'h0008_0008);

    // Clear counters, then W1C clears the alert.
    doWrite(2'd1, 32'd0, 1'b0, 1'b0);
    doWrite(2'd0, 32'h20, 1'b0, 1'b0);
    checkOutput("alert_w1c", {31'd0, alert}, 32'd0);

    // Uncorrected error sets alert; set beats a simultaneous W1C.
    applyStimulus(1'b1, 1'b0, 3'b000, 1);
    checkOutput("alert_uncorrected", {31'd0, alert}, 32'd1);
    doWrite(2'd0, 32'h20, 1'b1, 1'b0);
    checkOutput("alert_set_beats_clr", {31'd0, alert}, 32'd1);
    doRead(2'd1, readData, readData4);
    checkOutput("count_uncorrected", readData, 32'h0000_0002);

    // Counter clear wins over an error in the same cycle.
    doWrite(2'd1, 32'd0, 1'b1, 1'b1);
    doRead(2'd1, readData, readData4);
    checkOutput("count_clear_wins", readData, 32'h0000_0000);
    doWrite(2'd0, 32'h20, 1'b0, 1'b0);
    checkOutput("alert_cleared_again", {31'd0, alert}, 32'd0);

    // Corrected strobe without detection is ignored.
    applyStimulus(1'b0, 1'b1, 3'b000, 2);
    doRead(2'd1, readData, readData4);
    checkOutput("corr_only_ignored", readData, 32'h0000_0000);
    checkOutput("corr_only_no_alert", {31'd0, alert}, 32'd0);

    // Threshold register write/readback, then disable with zero.
    doWrite(2'd3, 32'hABCD_0003, 1'b0, 1'b0);
    doRead(2'd3, readData, readData4);
    checkOutput("thresh_write", readData, 32'h0000_0003);
    doWrite(2'd3, 32'd0, 1'b0, 1'b0);
    doRead(2'd3, readData, readData4);
    checkOutput("thresh_zero", readData, 32'h0000_0000);

    // FORCE register drives set_broken as a held level.
    doWrite(2'd2, 32'hFFFF_FFF4, 1'b0, 1'b0);
    checkOutput("force_level", {29'd0, set_broken}, 32'h4);
    applyStimulus(1'b0, 1'b0, 3'b000, 3);
    checkOutput("force_held", {29'd0, set_broken}, 32'h4);
    doRead(2'd2, readData, readData4);
    checkOutput("force_read", readData, 32'h0000_0004);

    // Health FSM: degraded, recover, fail, absorbing.
    applyStimulus(1'b0, 1'b0, 3'b001, 1);
    doRead(2'd0, readData, readData4);
    checkOutput("status_degraded", readData, 32'h0000_0005);
    applyStimulus(1'b0, 1'b0, 3'b000, 1);
    doRead(2'd0, readData, readData4);
    checkOutput("status_recovered", readData, 32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 3'b011, 2);
    doRead(2'd0, readData, readData4);
    checkOutput("status_failed", readData, 32'h0000_002E);
    checkOutput("alert_failed", {31'd0, alert}, 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b000, 3);
    doRead(2'd0, readData, readData4);
    checkOutput("status_failed_sticks", readData, 32'h0000_0022);

    // Saturation: 20 events on 16-bit and 4-bit counters.
    doWrite(2'd1, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b000, 20);
    doRead(2'd1, readData, readData4);
    checkOutput("count_20", readData, 32'h0014_0014);
    checkOutput("count_sat_w4", readData4, 32'h000F_000F);

    // Reset during a pending read drops the response and restores defaults.
    req  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    checkOutput("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_no_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("midrst_set_broken", {29'd0, set_broken}, 32'd0);
    checkOutput("midrst_alert", {31'd0, alert}, 32'd0);
    doRead(2'd0, readData, readData4);
    checkOutput("midrst_status", readData, 32'h0000_0000);
    doRead(2'd3, readData, readData4);
    checkOutput("midrst_thresh", readData, 32'h0000_0008);
    doRead(2'd1, readData, readData4);
    checkOutput("midrst_count", readData, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
